estagio_busca: RTL and testbench

Parametrised instruction-fetch stage for the pipelined MIPS32 core: owns the program counter, drives the instruction memory address, and buffers fetched `{pc, instrucao}` pairs in a small queue feeding decode. It replaces the fixed PC incrementer plus single IF/ID register pair with:
- a configurable reset vector, address width and queue depth;
- decode back-pressure (`parada`);
- branch/jump redirection with queue flush (`desvio`).

---
 rtl/estagio_busca_if.sv | 26 ++
 rtl/estagio_busca.sv | 62 ++++++
 tb/tb_estagio_busca.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/estagio_busca_if.sv
// estagio_busca_if: redirect, instruction memory and decode-side bus of the fetch stage
interface estagio_busca_if #(
   parameter int LARGURA_END  = 32,
   parameter int LARGURA_INST = 32,
   parameter int PROFUNDIDADE = 4
);
   logic                            desvio;
   logic [LARGURA_END-1:0]          alvo_desvio;
   logic [LARGURA_END-1:0]          mem_end;
   logic [LARGURA_INST-1:0]         mem_inst;
   logic                            parada;
   logic                            saida_valida;
   logic [LARGURA_END-1:0]          saida_pc;
   logic [LARGURA_INST-1:0]         saida_inst;
   logic                            fila_cheia;
   logic [$clog2(PROFUNDIDADE):0]   ocupacao;
   logic [31:0]                     bolhas;
   modport master (
      input  desvio, alvo_desvio, mem_inst, parada,
      output mem_end, saida_valida, saida_pc, saida_inst, fila_cheia, ocupacao, bolhas
   );
   modport slave (
      output desvio, alvo_desvio, mem_inst, parada,
      input  mem_end, saida_valida, saida_pc, saida_inst, fila_cheia, ocupacao, bolhas
   );
endinterface

// File: rtl/estagio_busca.sv
// estagio_busca: MIPS32 fetch stage with PC, fetch queue, stall and redirect flush.
// Define ESTAGIO_BUSCA_BOLHAS_EN to build the saturating bubble counter on bolhas.
module estagio_busca #(
   parameter int                     LARGURA_END  = 32,
   parameter int                     LARGURA_INST = 32,
   parameter int                     PROFUNDIDADE = 4,
   parameter logic [LARGURA_END-1:0] PC_RESET     = '0
) (
   input logic              clock,
   input logic              reset,
   estagio_busca_if.master  bus
);
   localparam int PW = $clog2(PROFUNDIDADE);
   logic [LARGURA_END-1:0]  pc;
   logic [PW:0]             wr, rd, ocup;
   logic [LARGURA_END-1:0]  fila_pc   [PROFUNDIDADE];
   logic [LARGURA_INST-1:0] fila_inst [PROFUNDIDADE];
   logic                    valida, cheia, push, pop;
   // extra wrap bit on the pointers separates full from empty
   assign ocup   = wr - rd;
   assign valida = wr != rd;
   assign cheia  = ocup == (PW+1)'(PROFUNDIDADE);
   assign pop    = valida & ~bus.parada;
   assign push   = ~bus.desvio & (~cheia | pop);
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         pc <= PC_RESET;
         wr <= '0;
         rd <= '0;
         for (int i = 0; i < PROFUNDIDADE; i++) begin
            fila_pc[i]   <= '0;
            fila_inst[i] <= '0;
         end
      end else if (bus.desvio) begin
         pc <= bus.alvo_desvio & ~LARGURA_END'(3);
         wr <= '0;
         rd <= '0;
      end else begin
         if (push) begin
            fila_pc[wr[PW-1:0]]   <= pc;
            fila_inst[wr[PW-1:0]] <= bus.mem_inst;
            wr <= wr + 1'b1;
            pc <= pc + LARGURA_END'(4);
         end
         if (pop) rd <= rd + 1'b1;
      end
   assign bus.mem_end      = pc;
   assign bus.saida_valida = valida;
   assign bus.saida_pc     = fila_pc[rd[PW-1:0]];
   assign bus.saida_inst   = fila_inst[rd[PW-1:0]];
   assign bus.fila_cheia   = cheia;
   assign bus.ocupacao     = ocup;
`ifdef ESTAGIO_BUSCA_BOLHAS_EN
   logic [31:0] cont;
   always_ff @(posedge clock or posedge reset)
      if (reset) cont <= '0;
      else if (!valida && cont != '1) cont <= cont + 32'd1;
   assign bus.bolhas = cont;
`else
   assign bus.bolhas = '0;
`endif
endmodule

// File: tb/tb_estagio_busca.sv
// tb_estagio_busca: scoreboard bench for estagio_busca (PC_RESET 0 and a wrapping instance)
module tb_estagio_busca;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;
   logic [31:0] m_q[$];
   logic [31:0] m_pc;
   logic [31:0] m_bol;
   estagio_busca_if #(.LARGURA_END(32), .LARGURA_INST(32), .PROFUNDIDADE(4)) bus0 ();
   estagio_busca_if #(.LARGURA_END(32), .LARGURA_INST(32), .PROFUNDIDADE(4)) bus1 ();
   estagio_busca #(.LARGURA_END(32), .LARGURA_INST(32), .PROFUNDIDADE(4), .PC_RESET(32'h0))
      u0 (.clock(clock), .reset(reset), .bus(bus0));
   estagio_busca #(.LARGURA_END(32), .LARGURA_INST(32), .PROFUNDIDADE(4), .PC_RESET(32'hFFFF_FFF8))
      u1 (.clock(clock), .reset(reset), .bus(bus1));
   assign bus0.mem_inst = bus0.mem_end;
   assign bus1.mem_inst = bus1.mem_end;
   always #5 clock = ~clock;
   function automatic logic [31:0] exp_bolhas();
`ifdef ESTAGIO_BUSCA_BOLHAS_EN
      return m_bol;
`else
      return 32'd0;
`endif
   endfunction
   task automatic do_reset();
      reset = 1'b1;
      bus0.parada = 1'b0; bus0.desvio = 1'b0; bus0.alvo_desvio = '0;
      bus1.parada = 1'b0; bus1.desvio = 1'b0; bus1.alvo_desvio = '0;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      m_q.delete();
      m_pc  = 32'h0;
      m_bol = 32'h0;
   endtask
   // scoreboard: compare against model at negedge, then advance model across the posedge
   task automatic step();
      logic pop, push;
      checks++;
      if (bus0.mem_end !== m_pc) begin errors++; $display("FAIL mem_end got=%h exp=%h", bus0.mem_end, m_pc); end
      checks++;
      if (bus0.saida_valida !== (m_q.size() != 0)) begin errors++; $display("FAIL saida_valida got=%b exp=%b", bus0.saida_valida, m_q.size() != 0); end
      checks++;
      if (bus0.ocupacao !== 3'(m_q.size())) begin errors++; $display("FAIL ocupacao got=%0d exp=%0d", bus0.ocupacao, m_q.size()); end
      checks++;
      if (bus0.bolhas !== exp_bolhas()) begin errors++; $display("FAIL bolhas got=%0d exp=%0d", bus0.bolhas, exp_bolhas()); end
      if (m_q.size() != 0) begin
         checks++;
         if (bus0.saida_pc !== m_q[0] || bus0.saida_inst !== m_q[0]) begin
            errors++; $display("FAIL head got pc=%h inst=%h exp=%h", bus0.saida_pc, bus0.saida_inst, m_q[0]);
         end
      end
      pop  = (m_q.size() != 0) && !bus0.parada;
      push = !bus0.desvio && (m_q.size() < 4 || pop);
      @(posedge clock);
      if (m_q.size() == 0 && m_bol != 32'hFFFF_FFFF) m_bol++;
      if (bus0.desvio) begin
         m_q.delete();
         m_pc = bus0.alvo_desvio & ~32'd3;
      end else begin
         if (pop) void'(m_q.pop_front());
         if (push) begin m_q.push_back(m_pc); m_pc += 32'd4; end
      end
      @(negedge clock);
   endtask
   task automatic test_reset();
      do_reset();
      checks++;
      if (bus0.mem_end !== 32'h0 || bus0.saida_valida !== 1'b0 || bus0.fila_cheia !== 1'b0 || bus0.ocupacao !== 3'd0) begin
         errors++; $display("FAIL reset_state end=%h v=%b full=%b ocup=%0d exp 0", bus0.mem_end, bus0.saida_valida, bus0.fila_cheia, bus0.ocupacao);
      end
      checks++;
      if (bus0.saida_pc !== 32'h0 || bus0.saida_inst !== 32'h0 || bus0.bolhas !== 32'h0) begin
         errors++; $display("FAIL reset_head pc=%h inst=%h bolhas=%0d exp 0", bus0.saida_pc, bus0.saida_inst, bus0.bolhas);
      end
   endtask
   task automatic test_free_run();
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (bus0.mem_end !== 32'(4 * (i + 1)) || bus0.saida_valida !== 1'b1 || bus0.saida_pc !== 32'(4 * i)) begin
            errors++; $display("FAIL free_run[%0d] end=%h v=%b pc=%h exp end=%h pc=%h", i, bus0.mem_end, bus0.saida_valida, bus0.saida_pc, 4 * (i + 1), 4 * i);
         end
      end
   endtask
   task automatic test_stall_full();
      do_reset();
      bus0.parada = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         step();
         checks++;
         if (bus0.ocupacao !== 3'(i) || bus0.fila_cheia !== (i == 4)) begin
            errors++; $display("FAIL stall_fill[%0d] ocup=%0d full=%b", i, bus0.ocupacao, bus0.fila_cheia);
         end
      end
      step();
      step();
      checks++;
      if (bus0.mem_end !== 32'h10 || bus0.ocupacao !== 3'd4) begin
         errors++; $display("FAIL stall_frozen end=%h ocup=%0d exp end=10 ocup=4", bus0.mem_end, bus0.ocupacao);
      end
      bus0.parada = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (bus0.saida_pc !== 32'(4 * i)) begin errors++; $display("FAIL drain[%0d] pc=%h exp=%h", i, bus0.saida_pc, 4 * i); end
         step();
      end
   endtask
   task automatic test_full_push_pop();
      do_reset();
      bus0.parada = 1'b1;
      repeat (5) step();
      bus0.parada = 1'b0;
      step();
      bus0.parada = 1'b1;
      checks++;
      if (bus0.ocupacao !== 3'd4 || bus0.fila_cheia !== 1'b1 || bus0.saida_pc !== 32'h4 || bus0.mem_end !== 32'h14) begin
         errors++; $display("FAIL push_pop ocup=%0d full=%b pc=%h end=%h exp 4 1 4 14", bus0.ocupacao, bus0.fila_cheia, bus0.saida_pc, bus0.mem_end);
      end
      step();
   endtask
   task automatic test_redirect(input logic hold);
      do_reset();
      bus0.parada = 1'b1;
      repeat (3) step();
      bus0.parada = hold;
      bus0.desvio = 1'b1;
      bus0.alvo_desvio = 32'h0000_0103;
      step();
      bus0.desvio = 1'b0;
      checks++;
      if (bus0.ocupacao !== 3'd0 || bus0.saida_valida !== 1'b0 || bus0.mem_end !== 32'h100) begin
         errors++; $display("FAIL redirect_n1 hold=%b ocup=%0d v=%b end=%h exp 0 0 100", hold, bus0.ocupacao, bus0.saida_valida, bus0.mem_end);
      end
      step();
      checks++;
      if (bus0.saida_valida !== 1'b1 || bus0.saida_pc !== 32'h100) begin
         errors++; $display("FAIL redirect_n2 hold=%b v=%b pc=%h exp 1 100", hold, bus0.saida_valida, bus0.saida_pc);
      end
      bus0.parada = 1'b0;
      repeat (2) step();
   endtask
   task automatic test_wrap_async();
      do_reset();
      checks++;
      if (bus1.mem_end !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap0 end=%h exp=fffffff8", bus1.mem_end); end
      step();
      checks++;
      if (bus1.mem_end !== 32'hFFFF_FFFC || bus1.saida_pc !== 32'hFFFF_FFF8) begin
         errors++; $display("FAIL wrap1 end=%h pc=%h exp fffffffc fffffff8", bus1.mem_end, bus1.saida_pc);
      end
      step();
      checks++;
      if (bus1.mem_end !== 32'h0 || bus1.saida_pc !== 32'hFFFF_FFFC) begin
         errors++; $display("FAIL wrap2 end=%h pc=%h exp 0 fffffffc", bus1.mem_end, bus1.saida_pc);
      end
      step();
      #2 reset = 1'b1;
      #1;
      checks++;
      if (bus0.saida_valida !== 1'b0 || bus1.saida_valida !== 1'b0 || bus0.mem_end !== 32'h0 || bus1.mem_end !== 32'hFFFF_FFF8) begin
         errors++; $display("FAIL async_reset v0=%b v1=%b end0=%h end1=%h", bus0.saida_valida, bus1.saida_valida, bus0.mem_end, bus1.mem_end);
      end
      @(negedge clock);
      reset = 1'b0;
      m_q.delete();
      m_pc  = 32'h0;
      m_bol = 32'h0;
      repeat (2) step();
   endtask
   task automatic test_bolhas();
      do_reset();
      repeat (3) step();
      bus0.desvio = 1'b1; bus0.alvo_desvio = 32'h40;
      step();
      bus0.desvio = 1'b0;
      repeat (2) step();
      bus0.desvio = 1'b1; bus0.alvo_desvio = 32'h80;
      step();
      bus0.desvio = 1'b0;
      repeat (3) step();
      checks++;
`ifdef ESTAGIO_BUSCA_BOLHAS_EN
      if (bus0.bolhas !== 32'd3) begin errors++; $display("FAIL bolhas_total got=%0d exp=3", bus0.bolhas); end
`else
      if (bus0.bolhas !== 32'd0) begin errors++; $display("FAIL bolhas_total got=%0d exp=0", bus0.bolhas); end
`endif
   endtask
   initial begin
      test_reset();
      test_free_run();
      test_stall_full();
      test_full_push_pop();
      test_redirect(1'b0);
      test_redirect(1'b1);
      test_wrap_async();
      test_bolhas();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
